// File: rtl/decode_stage.sv
// Decode stage: turns 16-bit fetched words into execute-stage control bundles.
// A two-state FSM collects the second word of LDM (the immediate) before
// presenting its bundle. Every output except in_ready is registered.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_instr,
  input  logic        in_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic        in_ready,
  output logic        out_valid,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  src_addr,
  output logic [2:0]  dst_addr,
  output logic [15:0] operand,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  typedef enum logic {
    DECODE   = 1'b0,
    WAIT_IMM = 1'b1
  } state_t;

  localparam logic [4:0] OP_SHL = 5'h09;
  localparam logic [4:0] OP_SHR = 5'h0A;
  localparam logic [4:0] OP_LDD = 5'h0D;
  localparam logic [4:0] OP_STD = 5'h0E;
  localparam logic [4:0] OP_LDM = 5'h0F;
  localparam logic [3:0] ALU_LDM = 4'd14;

  state_t     state;
  logic [2:0] ldm_src;
  logic [2:0] ldm_dst;

  logic [4:0] opcode;
  logic [2:0] fld_src;
  logic [2:0] fld_dst;
  logic [4:0] fld_shamt;
  logic       accept;

  // Decoded fields of the word on the input, before registering.
  logic [3:0]  dec_alu;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_illegal;
  logic [15:0] dec_operand;

  assign opcode    = in_instr[15:11];
  assign fld_src   = in_instr[10:8];
  assign fld_dst   = in_instr[7:5];
  assign fld_shamt = in_instr[4:0];

  // A stalled bundle blocks new input; a consumed or absent bundle frees the slot.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Opcode table for single-word instructions (LDM's own row is used in WAIT_IMM).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    dec_alu       = 4'd0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_illegal   = 1'b0;
    dec_operand   = 16'h0000;
    if (opcode[4]) begin
      dec_illegal = 1'b1;
    end else begin
      dec_alu       = (opcode == OP_STD) ? 4'd13 : opcode[3:0];
      dec_reg_write = !(opcode == 5'h00 || opcode == 5'h0B ||
                        opcode == 5'h0C || opcode == OP_STD);
      dec_mem_read  = (opcode == OP_LDD);
      dec_mem_write = (opcode == OP_STD);
      if (opcode == OP_SHL || opcode == OP_SHR)
        dec_operand = {11'b0, fld_shamt};
    end
  end

  // FSM and output registers: flush beats accept, accept beats drain.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DECODE;
      ldm_src   <= 3'd0;
      ldm_dst   <= 3'd0;
      out_valid <= 1'b0;
      alu_ctrl  <= 4'd0;
      src_addr  <= 3'd0;
      dst_addr  <= 3'd0;
      operand   <= 16'h0000;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      state     <= DECODE;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      if (state == WAIT_IMM) begin
        // Second LDM word is the immediate, whatever its opcode bits say.
        state     <= DECODE;
        out_valid <= 1'b1;
        alu_ctrl  <= ALU_LDM;
        src_addr  <= ldm_src;
        dst_addr  <= ldm_dst;
        operand   <= in_instr;
        reg_write <= 1'b1;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        illegal   <= 1'b0;
      end else if (opcode == OP_LDM) begin
        state     <= WAIT_IMM;
        ldm_src   <= fld_src;
        ldm_dst   <= fld_dst;
        out_valid <= 1'b0;
        illegal   <= 1'b0;
      end else begin
        out_valid <= 1'b1;
        alu_ctrl  <= dec_alu;
        src_addr  <= fld_src;
        dst_addr  <= fld_dst;
        operand   <= dec_operand;
        reg_write <= dec_reg_write;
        mem_read  <= dec_mem_read;
        mem_write <= dec_mem_write;
        illegal   <= dec_illegal;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed bundles for each scenario.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        out_ready;
  logic        flush;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  alu_ctrl;
  logic [2:0]  src_addr;
  logic [2:0]  dst_addr;
  logic [15:0] operand;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .alu_ctrl  (alu_ctrl),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .operand   (operand),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Advance one rising edge, then settle just after it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full bundle check of the registered outputs.
  task automatic check_bundle(input string tag, input logic v, input logic [3:0] alu,
                              input logic [2:0] src, input logic [2:0] dst,
                              input logic [15:0] opnd, input logic rw,
                              input logic mr, input logic mw, input logic ill);
    check({tag, ".out_valid"}, {15'b0, out_valid}, {15'b0, v});
    check({tag, ".alu_ctrl"},  {12'b0, alu_ctrl},  {12'b0, alu});
    check({tag, ".src_addr"},  {13'b0, src_addr},  {13'b0, src});
    check({tag, ".dst_addr"},  {13'b0, dst_addr},  {13'b0, dst});
    check({tag, ".operand"},   operand,            opnd);
    check({tag, ".reg_write"}, {15'b0, reg_write}, {15'b0, rw});
    check({tag, ".mem_read"},  {15'b0, mem_read},  {15'b0, mr});
    check({tag, ".mem_write"}, {15'b0, mem_write}, {15'b0, mw});
    check({tag, ".illegal"},   {15'b0, illegal},   {15'b0, ill});
  endtask

  initial begin
    rst       = 1'b1;
    in_instr  = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check_bundle("reset", 1'b0, 4'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.in_ready", {15'b0, in_ready}, 16'd1);

    // ADD r5 -> r2, one-cycle latency.
    in_instr = 16'h2D40; in_valid = 1'b1;
    step();
    check_bundle("add", 1'b1, 4'd5, 3'd5, 3'd2, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // LDM: no bundle after the first word, full bundle after the immediate.
    in_instr = 16'h7860;
    step();
    check("ldm1.out_valid", {15'b0, out_valid}, 16'd0);
    in_instr = 16'hBEEF;
    step();
    check_bundle("ldm2", 1'b1, 4'd14, 3'd0, 3'd3, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);

    // SHL r0 -> r1 by 7, then stall three cycles with NOT waiting.
    in_instr = 16'h4827;
    step();
    check_bundle("shl", 1'b1, 4'd9, 3'd0, 3'd1, 16'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0; in_instr = 16'h0800;
    #1;
    check("stall.in_ready", {15'b0, in_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_bundle("stall", 1'b1, 4'd9, 3'd0, 3'd1, 16'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      check("stall.in_ready", {15'b0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall.in_ready", {15'b0, in_ready}, 16'd1);
    step();
    check_bundle("unstall", 1'b1, 4'd1, 3'd0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush in WAIT_IMM drops the half-LDM and the simultaneous word.
    in_instr = 16'h7860;
    step();
    check("fl_ldm.out_valid", {15'b0, out_valid}, 16'd0);
    flush = 1'b1; in_instr = 16'h1234;
    step();
    check("flush.out_valid", {15'b0, out_valid}, 16'd0);
    flush = 1'b0; in_instr = 16'h0800;
    step();
    check_bundle("post_flush", 1'b1, 4'd1, 3'd0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush with a valid bundle clears out_valid.
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    step();
    check("flush_valid.out_valid", {15'b0, out_valid}, 16'd0);
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;

    // SHR by 31, LDD, STD.
    in_instr = 16'h501F;
    step();
    check_bundle("shr", 1'b1, 4'd10, 3'd0, 3'd0, 16'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    in_instr = 16'h6940;
    step();
    check_bundle("ldd", 1'b1, 4'd13, 3'd1, 3'd2, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    in_instr = 16'h7140;
    step();
    check_bundle("std", 1'b1, 4'd13, 3'd1, 3'd2, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // SETC: no register write.
    in_instr = 16'h5800;
    step();
    check_bundle("setc", 1'b1, 4'd11, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal opcode, then a legal word clears illegal.
    in_instr = 16'hF800;
    step();
    check_bundle("illegal", 1'b1, 4'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    in_instr = 16'h0800;
    step();
    check_bundle("after_ill", 1'b1, 4'd1, 3'd0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Drain with no input: out_valid drops.
    in_valid = 1'b0;
    step();
    check("drain.out_valid", {15'b0, out_valid}, 16'd0);

    // Asynchronous reset between edges clears everything immediately.
    in_valid = 1'b1; in_instr = 16'hF800;
    step();
    check("pre_rst.illegal", {15'b0, illegal}, 16'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_bundle("async_rst", 1'b0, 4'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-LDM discards the first word.
    in_valid = 1'b1; in_instr = 16'h7860;
    step();
    check("rst_ldm1.out_valid", {15'b0, out_valid}, 16'd0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0800;
    step();
    check_bundle("rst_mid_ldm", 1'b1, 4'd1, 3'd0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // WAIT_IMM waits indefinitely for the immediate.
    in_instr = 16'h7E60;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("wait_imm.out_valid", {15'b0, out_valid}, 16'd0);
    end
    in_valid = 1'b1; in_instr = 16'hA5A5;
    step();
    check_bundle("late_imm", 1'b1, 4'd14, 3'd6, 3'd3, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have these inputs: in_instr  in  16  fetched word; in_valid  in  1  word present; out_ready  in  1  execute stage accepts; flush  in  1  synchronous discard.
REQ-003 SHALL have these outputs: in_ready  out  1  word accepted this cycle; out_valid  out  1  decoded bundle valid; alu_ctrl  out  4  ALU function code 0..14; src_addr  out  3  source register; dst_addr  out  3  destination register; operand  out  16  shift amount or immediate; reg_write  out  1; mem_read  out  1; mem_write  out  1; illegal  out  1  undefined opcode.
REQ-004 SHALL use the instruction fields opcode=in_instr[15:11], src=[10:8], dst=[7:5], shamt=[4:0].

Function
REQ-005 SHALL map the opcode to alu_ctrl/reg_write as follows: 00 NOP->0/0; 01 NOT->1/1; 02 INC->2/1; 03 DEC->3/1; 04 MOV->4/1; 05 ADD->5/1; 06 SUB->6/1; 07 AND->7/1; 08 OR->8/1; 09 SHL->9/1; 0A SHR->10/1; 0B SETC->11/0; 0C CLRC->12/0; 0D LDD->13/1 with mem_read=1; 0E STD->13/0 with mem_write=1; 0F LDM->14/1.
REQ-006 SHALL treat opcodes 10..1F as illegal: alu_ctrl=0, all write/read strobes 0, illegal=1 for that bundle only.
REQ-007 SHALL drive operand={11'b0,shamt} for SHL/SHR, the second fetched word for LDM, and 0 for all other opcodes.
REQ-008 SHALL drive in_ready = !out_valid || out_ready (combinational), and SHALL accept a word on any rising edge where in_valid && in_ready && !flush.
REQ-009 SHALL register all outputs except in_ready: a single-word instruction accepted at edge k SHALL appear with out_valid=1 after edge k (1-cycle latency).
REQ-010 SHALL implement a two-state FSM. In DECODE, accepting LDM SHALL latch src/dst and move to WAIT_IMM with out_valid=0. Accepting any other opcode SHALL stay in DECODE.
REQ-011 In WAIT_IMM, the next accepted word SHALL be taken verbatim as the immediate, whatever its opcode bits. The FSM SHALL then present the LDM bundle with out_valid=1 and return to DECODE.
REQ-012 SHALL hold every output stable while out_valid=1 and out_ready=0 (stall), and SHALL accept no word during the stall.
REQ-013 If out_valid && out_ready and an accept occur on the same edge, SHALL replace the bundle with no bubble. If out_ready occurs without an accept, SHALL clear out_valid.
REQ-014 SHALL give flush priority over accept: flush=1 at an edge SHALL clear out_valid and illegal, return the FSM to DECODE, discard any half-received LDM, and drop a simultaneously presented word.
REQ-015 In WAIT_IMM with in_valid=0, SHALL wait indefinitely with no timeout.

Reset
REQ-016 While rst=1, SHALL force FSM=DECODE, out_valid=0, alu_ctrl=0, src_addr=0, dst_addr=0, operand=0, all strobes 0, illegal=0, independent of clk.
REQ-017 After rst deasserts, SHALL accept input at the first rising edge where the REQ-008 conditions hold. Reset mid-LDM SHALL discard the first word.

Verification
REQ-018 ADD: in_instr=16'h2D40 (op05, src5, dst2), out_ready=1 -> next cycle alu_ctrl=5, src_addr=5, dst_addr=2, reg_write=1, operand=0, out_valid=1.
REQ-019 LDM: 16'h7860 then 16'hBEEF on consecutive cycles -> out_valid=0 after the first word. After the second: alu_ctrl=14, dst_addr=3, operand=16'hBEEF, reg_write=1.
REQ-020 Stall: SHL 16'h4827 (shamt 7) held with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs unchanged with operand=7. out_ready=1 -> next word is accepted with no bubble.
REQ-021 Flush in WAIT_IMM: LDM first word, then flush=1 with in_valid=1 and 16'h1234 -> out_valid=0, FSM=DECODE. The next word 16'h0800 (NOT) decodes as alu_ctrl=1.
REQ-022 Illegal/reset: 16'hF800 -> illegal=1, alu_ctrl=0, strobes 0. Asserting rst between the clock edges -> all outputs 0 immediately.
